// File: rtl/totd_cfg_sequencer.sv
// ToTd trigger controller: 3-phase ENABLE40 strobe, double-buffered trigger
// configuration applied atomically on the phase-2 edge, and trigger qualification.
module totd_cfg_sequencer #(
    parameter int unsigned ADC_WIDTH    = 12,
    parameter int unsigned OCC_BITS     = 7,
    parameter int unsigned INT_BITS     = 20,
    parameter int unsigned SETTLE_TICKS = 121,
    parameter int unsigned HOLDOFF_BITS = 8
) (
    input  logic                    CLK120,
    input  logic                    RESETN,
    input  logic                    SYNC40,
    input  logic                    WR_STB,
    input  logic [3:0]              WR_ADDR,
    input  logic [31:0]             WR_DATA,
    input  logic                    COMMIT,
    input  logic                    TRIG_IN,
    output logic [1:0]              ENABLE40,
    output logic [ADC_WIDTH-1:0]    THRES0,
    output logic [ADC_WIDTH-1:0]    THRES1,
    output logic [ADC_WIDTH-1:0]    THRES2,
    output logic [ADC_WIDTH-1:0]    UP0,
    output logic [ADC_WIDTH-1:0]    UP1,
    output logic [ADC_WIDTH-1:0]    UP2,
    output logic [OCC_BITS-1:0]     OCCUPANCY,
    output logic [INT_BITS-1:0]     INT,
    output logic [2:0]              TRIG_ENABLE,
    output logic [1:0]              MULTIPLICITY,
    output logic                    TRIG_OUT,
    output logic                    BUSY,
    output logic                    COMMIT_ACK,
    output logic                    WR_ERR,
    output logic [15:0]             DROP_CNT
);

    localparam int unsigned CNT_W = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              en40_q, en40_d;
    logic [CNT_W-1:0]        settle_q, settle_d;

    logic [ADC_WIDTH-1:0]    stg_thres_q [3];
    logic [ADC_WIDTH-1:0]    stg_thres_d [3];
    logic [ADC_WIDTH-1:0]    stg_up_q [3];
    logic [ADC_WIDTH-1:0]    stg_up_d [3];
    logic [OCC_BITS-1:0]     stg_occ_q, stg_occ_d;
    logic [INT_BITS-1:0]     stg_int_q, stg_int_d;
    logic [2:0]              stg_ten_q, stg_ten_d;
    logic [1:0]              stg_mult_q, stg_mult_d;
    logic [HOLDOFF_BITS-1:0] stg_hold_q, stg_hold_d;

    logic [ADC_WIDTH-1:0]    act_thres_q [3];
    logic [ADC_WIDTH-1:0]    act_thres_d [3];
    logic [ADC_WIDTH-1:0]    act_up_q [3];
    logic [ADC_WIDTH-1:0]    act_up_d [3];
    logic [OCC_BITS-1:0]     act_occ_q, act_occ_d;
    logic [INT_BITS-1:0]     act_int_q, act_int_d;
    logic [2:0]              act_ten_q, act_ten_d;
    logic [1:0]              act_mult_q, act_mult_d;
    logic [HOLDOFF_BITS-1:0] act_hold_q, act_hold_d;

    logic [HOLDOFF_BITS-1:0] holdoff_q, holdoff_d;
    logic                    trig_in_q, trig_in_d;
    logic                    rise_q, rise_d;
    logic                    trig_out_q, trig_out_d;
    logic                    busy_q, busy_d;
    logic                    ack_q, ack_d;
    logic                    wr_err_q, wr_err_d;
    logic [15:0]             drop_q, drop_d;
    logic                    wr_ok;
    logic                    unused_wr_data;

    assign unused_wr_data = ^WR_DATA;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        stg_thres_d = stg_thres_q;
        stg_up_d    = stg_up_q;
        stg_occ_d   = stg_occ_q;
        stg_int_d   = stg_int_q;
        stg_ten_d   = stg_ten_q;
        stg_mult_d  = stg_mult_q;
        stg_hold_d  = stg_hold_q;
        act_thres_d = act_thres_q;
        act_up_d    = act_up_q;
        act_occ_d   = act_occ_q;
        act_int_d   = act_int_q;
        act_ten_d   = act_ten_q;
        act_mult_d  = act_mult_q;
        act_hold_d  = act_hold_q;
        holdoff_d   = holdoff_q;
        drop_d      = drop_q;
        ack_d       = 1'b0;
        wr_err_d    = 1'b0;
        trig_out_d  = 1'b0;
        trig_in_d   = TRIG_IN;
        rise_d      = TRIG_IN & ~trig_in_q;

        if (SYNC40 || en40_q == 2'd2) begin
            en40_d = 2'd0;
        end else begin
            en40_d = en40_q + 2'd1;
        end

        // Staging is frozen while a commit is pending so the apply stays atomic
        wr_ok = WR_STB && (state_q != ST_PEND) && (WR_ADDR <= 4'd9);
        if (WR_STB && !wr_ok) begin
            wr_err_d = 1'b1;
        end
        if (wr_ok) begin
            case (WR_ADDR)
                4'd0: stg_thres_d[0] = WR_DATA[ADC_WIDTH-1:0];
                4'd1: stg_thres_d[1] = WR_DATA[ADC_WIDTH-1:0];
                4'd2: stg_thres_d[2] = WR_DATA[ADC_WIDTH-1:0];
                4'd3: stg_up_d[0]    = WR_DATA[ADC_WIDTH-1:0];
                4'd4: stg_up_d[1]    = WR_DATA[ADC_WIDTH-1:0];
                4'd5: stg_up_d[2]    = WR_DATA[ADC_WIDTH-1:0];
                4'd6: stg_occ_d      = WR_DATA[OCC_BITS-1:0];
                4'd7: begin
                    stg_ten_d  = WR_DATA[2:0];
                    stg_mult_d = WR_DATA[4:3];
                end
                4'd8: stg_int_d      = WR_DATA[INT_BITS-1:0];
                4'd9: stg_hold_d     = WR_DATA[HOLDOFF_BITS-1:0];
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (COMMIT) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (en40_q == 2'd2) begin
                    state_d     = ST_SETTLE;
                    settle_d    = CNT_W'(SETTLE_TICKS);
                    ack_d       = 1'b1;
                    act_thres_d = stg_thres_q;
                    act_up_d    = stg_up_q;
                    act_occ_d   = stg_occ_q;
                    act_int_d   = stg_int_q;
                    act_ten_d   = stg_ten_q;
                    act_mult_d  = stg_mult_q;
                    act_hold_d  = stg_hold_q;
                end
            end
            ST_SETTLE: begin
                if (COMMIT) begin
                    state_d = ST_PEND;
                end else if (settle_q == '0) begin
                    state_d = ST_IDLE;
                end else if (en40_q == 2'd0) begin
                    settle_d = settle_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);

        if (holdoff_q != '0 && en40_q == 2'd0) begin
            holdoff_d = holdoff_q - HOLDOFF_BITS'(1);
        end
        if (rise_q) begin
            if (state_q == ST_IDLE && holdoff_q == '0) begin
                trig_out_d = 1'b1;
                holdoff_d  = act_hold_q;
            end else if (drop_q != '1) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK120 or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= ST_IDLE;
            en40_q      <= '0;
            settle_q    <= '0;
            stg_thres_q <= '{default: '1};
            stg_up_q    <= '{default: '1};
            stg_occ_q   <= '1;
            stg_int_q   <= '1;
            stg_ten_q   <= '0;
            stg_mult_q  <= '0;
            stg_hold_q  <= '0;
            act_thres_q <= '{default: '1};
            act_up_q    <= '{default: '1};
            act_occ_q   <= '1;
            act_int_q   <= '1;
            act_ten_q   <= '0;
            act_mult_q  <= '0;
            act_hold_q  <= '0;
            holdoff_q   <= '0;
            trig_in_q   <= 1'b0;
            rise_q      <= 1'b0;
            trig_out_q  <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            wr_err_q    <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            en40_q      <= en40_d;
            settle_q    <= settle_d;
            stg_thres_q <= stg_thres_d;
            stg_up_q    <= stg_up_d;
            stg_occ_q   <= stg_occ_d;
            stg_int_q   <= stg_int_d;
            stg_ten_q   <= stg_ten_d;
            stg_mult_q  <= stg_mult_d;
            stg_hold_q  <= stg_hold_d;
            act_thres_q <= act_thres_d;
            act_up_q    <= act_up_d;
            act_occ_q   <= act_occ_d;
            act_int_q   <= act_int_d;
            act_ten_q   <= act_ten_d;
            act_mult_q  <= act_mult_d;
            act_hold_q  <= act_hold_d;
            holdoff_q   <= holdoff_d;
            trig_in_q   <= trig_in_d;
            rise_q      <= rise_d;
            trig_out_q  <= trig_out_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            wr_err_q    <= wr_err_d;
            drop_q      <= drop_d;
        end
    end

    assign ENABLE40     = en40_q;
    assign THRES0       = act_thres_q[0];
    assign THRES1       = act_thres_q[1];
    assign THRES2       = act_thres_q[2];
    assign UP0          = act_up_q[0];
    assign UP1          = act_up_q[1];
    assign UP2          = act_up_q[2];
    assign OCCUPANCY    = act_occ_q;
    assign INT          = act_int_q;
    assign TRIG_ENABLE  = act_ten_q;
    assign MULTIPLICITY = act_mult_q;
    assign TRIG_OUT     = trig_out_q;
    assign BUSY         = busy_q;
    assign COMMIT_ACK   = ack_q;
    assign WR_ERR       = wr_err_q;
    assign DROP_CNT     = drop_q;

endmodule
